dds_sweep_controller: RTL and testbench

Sequencing controller for the square-wave DDS phase accumulator. It steps the accumulator's frequency word from a start value to a stop value in fixed increments and holds each value for a programmable dwell time. On request it repeats the sweep indefinitely. It sits between the register/config interface and the DDS generator, drives the generator's `frequency` and `phase` inputs, and reports progress to the host through `busy`, `done` and strobe outputs.

---
 rtl/dds_sweep_controller.sv | 183 ++++++++++++++++++
 tb/tb_dds_sweep_controller.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/dds_sweep_controller.sv
// ---------------------------------------------------------------------------
// dds_sweep_controller
//
// Steps the DDS frequency word from a start value to a stop value in fixed,
// clamped increments, holding each point for a programmable number of
// clocks. Optionally repeats the sweep until aborted. A phase offset is
// presented for exactly one cycle at sweep start because the DDS adds
// `phase` on every clock.
//
// Ports
//   clk            in   system clock
//   rst            in   asynchronous, active-high reset
//   start          in   sweep request (sampled in IDLE only)
//   abort          in   terminate sweep (sampled in RUN only)
//   cfg_start_freq in   first frequency word
//   cfg_stop_freq  in   last frequency word
//   cfg_step       in   unsigned step magnitude
//   cfg_dwell      in   clocks per frequency point
//   cfg_phase      in   one-shot phase offset at sweep start
//   cfg_repeat     in   1 = restart from start after the stop point
//   frequency      out  frequency word to the DDS
//   phase          out  phase offset to the DDS (nonzero one cycle only)
//   busy           out  sweep in progress
//   done           out  one-cycle pulse when a non-repeating sweep ends
//   step_strobe    out  one-cycle pulse on every new sweep point
//   cfg_error      out  one-cycle pulse when a start is rejected
// ---------------------------------------------------------------------------
module dds_sweep_controller #(
    parameter int ACC_WIDTH   = 32,
    parameter int DWELL_WIDTH = 24
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic [ACC_WIDTH-1:0]   cfg_start_freq,
    input  logic [ACC_WIDTH-1:0]   cfg_stop_freq,
    input  logic [ACC_WIDTH-1:0]   cfg_step,
    input  logic [DWELL_WIDTH-1:0] cfg_dwell,
    input  logic [ACC_WIDTH-1:0]   cfg_phase,
    input  logic                   cfg_repeat,
    output logic [ACC_WIDTH-1:0]   frequency,
    output logic [ACC_WIDTH-1:0]   phase,
    output logic                   busy,
    output logic                   done,
    output logic                   step_strobe,
    output logic                   cfg_error
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [DWELL_WIDTH-1:0] dwell_one = {{(DWELL_WIDTH-1){1'b0}}, 1'b1};

    state_t                 state, state_n;
    logic [ACC_WIDTH-1:0]   frequency_n, phase_n;
    logic                   busy_n, done_n, step_strobe_n, cfg_error_n;
    logic [DWELL_WIDTH-1:0] dwell_cnt, dwell_cnt_n;

    // Shadow copies of the configuration, frozen for the whole sweep.
    logic [ACC_WIDTH-1:0]   sh_start, sh_start_n;
    logic [ACC_WIDTH-1:0]   sh_stop, sh_stop_n;
    logic [ACC_WIDTH-1:0]   sh_step, sh_step_n;
    logic [DWELL_WIDTH-1:0] sh_dwell, sh_dwell_n;
    logic                   sh_repeat, sh_repeat_n;
    logic                   sh_up, sh_up_n;

    logic [ACC_WIDTH-1:0]   remaining;
    logic [ACC_WIDTH-1:0]   next_point;

    // Clamped next point: compare the distance still to go against the step
    // instead of adding first, so the word can never wrap past stop.
    always_comb begin
        remaining  = sh_up ? (sh_stop - frequency) : (frequency - sh_stop);
        next_point = sh_stop;
        if (remaining > sh_step) begin
            next_point = sh_up ? (frequency + sh_step) : (frequency - sh_step);
        end
    end

    always_comb begin
        // NOTE: every signal written here gets a default first; a path that
        // left one unassigned would infer a latch.
        state_n       = state;
        frequency_n   = frequency;
        phase_n       = '0;
        busy_n        = busy;
        done_n        = 1'b0;
        step_strobe_n = 1'b0;
        cfg_error_n   = 1'b0;
        dwell_cnt_n   = dwell_cnt;
        sh_start_n    = sh_start;
        sh_stop_n     = sh_stop;
        sh_step_n     = sh_step;
        sh_dwell_n    = sh_dwell;
        sh_repeat_n   = sh_repeat;
        sh_up_n       = sh_up;

        unique case (state)
            IDLE: begin
                if (start) begin
                    if (cfg_step == '0 || cfg_dwell == '0) begin
                        cfg_error_n = 1'b1;
                    end else begin
                        sh_start_n    = cfg_start_freq;
                        sh_stop_n     = cfg_stop_freq;
                        sh_step_n     = cfg_step;
                        sh_dwell_n    = cfg_dwell;
                        sh_repeat_n   = cfg_repeat;
                        sh_up_n       = (cfg_stop_freq >= cfg_start_freq);
                        state_n       = RUN;
                        frequency_n   = cfg_start_freq;
                        phase_n       = cfg_phase;
                        step_strobe_n = 1'b1;
                        busy_n        = 1'b1;
                        dwell_cnt_n   = cfg_dwell - dwell_one;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    state_n     = IDLE;
                    frequency_n = '0;
                    busy_n      = 1'b0;
                end else if (dwell_cnt != '0) begin
                    dwell_cnt_n = dwell_cnt - dwell_one;
                end else if (frequency != sh_stop) begin
                    frequency_n   = next_point;
                    step_strobe_n = 1'b1;
                    dwell_cnt_n   = sh_dwell - dwell_one;
                end else if (sh_repeat) begin
                    frequency_n   = sh_start;
                    step_strobe_n = 1'b1;
                    dwell_cnt_n   = sh_dwell - dwell_one;
                end else begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            frequency   <= '0;
            phase       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            step_strobe <= 1'b0;
            cfg_error   <= 1'b0;
            dwell_cnt   <= '0;
            sh_start    <= '0;
            sh_stop     <= '0;
            sh_step     <= '0;
            sh_dwell    <= '0;
            sh_repeat   <= 1'b0;
            sh_up       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge value of the others, independent of statement order.
            state       <= state_n;
            frequency   <= frequency_n;
            phase       <= phase_n;
            busy        <= busy_n;
            done        <= done_n;
            step_strobe <= step_strobe_n;
            cfg_error   <= cfg_error_n;
            dwell_cnt   <= dwell_cnt_n;
            sh_start    <= sh_start_n;
            sh_stop     <= sh_stop_n;
            sh_step     <= sh_step_n;
            sh_dwell    <= sh_dwell_n;
            sh_repeat   <= sh_repeat_n;
            sh_up       <= sh_up_n;
        end
    end

endmodule

// File: tb/tb_dds_sweep_controller.sv
// ---------------------------------------------------------------------------
// tb_dds_sweep_controller
//
// Directed bench for dds_sweep_controller. Inputs change 1 time unit after
// the rising edge; outputs are sampled at the same point, so the value seen
// right after the edge that samples `start` is the "T+1" value.
// ---------------------------------------------------------------------------
module tb_dds_sweep_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [31:0] cfg_start_freq;
    logic [31:0] cfg_stop_freq;
    logic [31:0] cfg_step;
    logic [23:0] cfg_dwell;
    logic [31:0] cfg_phase;
    logic        cfg_repeat;
    logic [31:0] frequency;
    logic [31:0] phase;
    logic        busy;
    logic        done;
    logic        step_strobe;
    logic        cfg_error;

    int compared   = 0;
    int mismatched = 0;

    dds_sweep_controller #(
        .ACC_WIDTH   (32),
        .DWELL_WIDTH (24)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .abort          (abort),
        .cfg_start_freq (cfg_start_freq),
        .cfg_stop_freq  (cfg_stop_freq),
        .cfg_step       (cfg_step),
        .cfg_dwell      (cfg_dwell),
        .cfg_phase      (cfg_phase),
        .cfg_repeat     (cfg_repeat),
        .frequency      (frequency),
        .phase          (phase),
        .busy           (busy),
        .done           (done),
        .step_strobe    (step_strobe),
        .cfg_error      (cfg_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check every output against the expected values for this cycle, then
    // move to the next sample point.
    task automatic expect_cycle(input string tag, input logic [31:0] f, input logic [31:0] ph,
                                input logic st, input logic b, input logic d);
        check({tag, ".frequency"},   frequency,          f);
        check({tag, ".phase"},       phase,              ph);
        check({tag, ".step_strobe"}, 32'(step_strobe),   32'(st));
        check({tag, ".busy"},        32'(busy),          32'(b));
        check({tag, ".done"},        32'(done),          32'(d));
        check({tag, ".cfg_error"},   32'(cfg_error),     32'd0);
        tick();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".frequency"},   frequency,        32'd0);
        check({tag, ".phase"},       phase,            32'd0);
        check({tag, ".busy"},        32'(busy),        32'd0);
        check({tag, ".done"},        32'(done),        32'd0);
        check({tag, ".step_strobe"}, 32'(step_strobe), 32'd0);
        check({tag, ".cfg_error"},   32'(cfg_error),   32'd0);
    endtask

    task automatic configure(input logic [31:0] sf, input logic [31:0] ef, input logic [31:0] stp,
                             input logic [23:0] dw, input logic [31:0] ph, input logic rep);
        cfg_start_freq = sf;
        cfg_stop_freq  = ef;
        cfg_step       = stp;
        cfg_dwell      = dw;
        cfg_phase      = ph;
        cfg_repeat     = rep;
    endtask

    task automatic launch();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        configure(32'd0, 32'd0, 32'd0, 24'd0, 32'd0, 1'b0);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        // Up sweep; a second start and a config change mid-sweep must be ignored
        configure(32'd100, 32'd400, 32'd100, 24'd3, 32'h4000_0000, 1'b0);
        launch();
        for (int p = 0; p < 4; p++) begin
            for (int k = 0; k < 3; k++) begin
                if (p == 1 && k == 1) begin
                    start          = 1'b1;
                    cfg_stop_freq  = 32'd9999;
                    cfg_start_freq = 32'd7;
                end else begin
                    start = 1'b0;
                end
                expect_cycle("up", 32'(100 * (p + 1)),
                             (p == 0 && k == 0) ? 32'h4000_0000 : 32'd0,
                             (k == 0), 1'b1, 1'b0);
            end
        end
        expect_cycle("up_done", 32'd400, 32'd0, 1'b0, 1'b0, 1'b1);
        expect_cycle("up_idle", 32'd400, 32'd0, 1'b0, 1'b0, 1'b0);

        // Rejected starts: step == 0, then dwell == 0
        configure(32'd1, 32'd2, 32'd0, 24'd5, 32'd9, 1'b0);
        launch();
        check("rej_step.cfg_error", 32'(cfg_error), 32'd1);
        check("rej_step.busy",      32'(busy),      32'd0);
        check("rej_step.frequency", frequency,      32'd400);
        check("rej_step.phase",     phase,          32'd0);
        tick();
        check("rej_step.pulse_end", 32'(cfg_error), 32'd0);
        configure(32'd1, 32'd2, 32'd1, 24'd0, 32'd9, 1'b0);
        launch();
        check("rej_dwell.cfg_error", 32'(cfg_error),   32'd1);
        check("rej_dwell.strobe",    32'(step_strobe), 32'd0);
        tick();

        // Down sweep with clamp onto the stop point
        configure(32'd1000, 32'd250, 32'd300, 24'd1, 32'd5, 1'b0);
        launch();
        expect_cycle("down", 32'd1000, 32'd5, 1'b1, 1'b1, 1'b0);
        expect_cycle("down", 32'd700,  32'd0, 1'b1, 1'b1, 1'b0);
        expect_cycle("down", 32'd400,  32'd0, 1'b1, 1'b1, 1'b0);
        expect_cycle("down", 32'd250,  32'd0, 1'b1, 1'b1, 1'b0);
        expect_cycle("down_done", 32'd250, 32'd0, 1'b0, 1'b0, 1'b1);

        // Wrap guard near the top of the word
        configure(32'hFFFF_FF00, 32'hFFFF_FFFF, 32'h80, 24'd1, 32'd0, 1'b0);
        launch();
        expect_cycle("wrap", 32'hFFFF_FF00, 32'd0, 1'b1, 1'b1, 1'b0);
        expect_cycle("wrap", 32'hFFFF_FF80, 32'd0, 1'b1, 1'b1, 1'b0);
        expect_cycle("wrap", 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b1, 1'b0);
        expect_cycle("wrap_done", 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0, 1'b1);

        // Repeat then abort: 0,0,1,1,2,2,0,0,1,1,2 ...
        configure(32'd0, 32'd2, 32'd1, 24'd2, 32'h123, 1'b1);
        launch();
        for (int i = 0; i < 10; i++) begin
            expect_cycle("rep", 32'((i / 2) % 3), (i == 0) ? 32'h123 : 32'd0,
                         (i % 2 == 0), 1'b1, 1'b0);
        end
        abort = 1'b1;
        expect_cycle("abort_edge", 32'd2, 32'd0, 1'b1, 1'b1, 1'b0);
        abort = 1'b0;
        expect_cycle("abort", 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        expect_cycle("abort_idle", 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a dwell
        configure(32'd100, 32'd400, 32'd100, 24'd3, 32'd0, 1'b0);
        launch();
        expect_cycle("pre_rst", 32'd100, 32'd0, 1'b1, 1'b1, 1'b0);
        expect_cycle("pre_rst", 32'd100, 32'd0, 1'b0, 1'b1, 1'b0);
        check("pre_rst.busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #2;
        check_all_zero("async_rst");
        #1;
        rst = 1'b0;
        tick();
        check_all_zero("post_rst");

        // Fresh sweep after reset release
        configure(32'd10, 32'd30, 32'd10, 24'd1, 32'd7, 1'b0);
        launch();
        expect_cycle("fresh", 32'd10, 32'd7, 1'b1, 1'b1, 1'b0);
        expect_cycle("fresh", 32'd20, 32'd0, 1'b1, 1'b1, 1'b0);
        expect_cycle("fresh", 32'd30, 32'd0, 1'b1, 1'b1, 1'b0);
        expect_cycle("fresh_done", 32'd30, 32'd0, 1'b0, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
